// File: rtl/npa_apb_pkg.sv
// rtl/npa_apb_pkg.sv - shared types and helpers for the APB traffic requester family
package npa_apb_pkg;

   localparam int NPA_WAIT_W = 16;
   localparam int NPA_ADDR_W = 32;
   localparam int NPA_DATA_W = 32;
   localparam int NPA_STRB_W = NPA_DATA_W / 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } apb_mst_state_e;

   typedef struct packed {
      logic                  write;
      logic [NPA_ADDR_W-1:0] addr;
      logic [NPA_DATA_W-1:0] wdata;
      logic [NPA_STRB_W-1:0] strb;
   } npa_apb_cmd_t;

   // Wait counts pin at all-ones instead of wrapping back to a small value.
   function automatic logic [NPA_WAIT_W-1:0] npa_sat_inc(input logic [NPA_WAIT_W-1:0] v);
      return (&v) ? v : v + NPA_WAIT_W'(1);
   endfunction

endpackage

// File: rtl/npa_sync_fifo.sv
// rtl/npa_sync_fifo.sv - single-clock FIFO with registered occupancy count
module npa_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [PW:0]   DEPTH_C  = (PW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == DEPTH_C);
   assign empty    = (count == '0);
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + (PW + 1)'(1);
            2'b01:   count <= count - (PW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/apb_traffic_master.sv
// rtl/apb_traffic_master.sv - APB4 requester: queued commands in, one response per transfer out
module apb_traffic_master
   import npa_apb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int CMD_DEPTH  = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic                    PCLK,
   input  logic                    PRESET,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_strb,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err,
   output logic                    rsp_timeout,
   output logic [NPA_WAIT_W-1:0]   rsp_wait,
   output logic                    PSEL,
   output logic                    PENABLE,
   output logic                    PWRITE,
   output logic [ADDR_WIDTH-1:0]   PADDR,
   output logic [DATA_WIDTH-1:0]   PWDATA,
   output logic [DATA_WIDTH/8-1:0] PSTRB,
   input  logic [DATA_WIDTH-1:0]   PRDATA,
   input  logic                    PREADY,
   input  logic                    PSLVERR
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int CMD_WIDTH  = 1 + ADDR_WIDTH + DATA_WIDTH + STRB_WIDTH;
   localparam logic [31:0] TIMEOUT_C = 32'(TIMEOUT);

   apb_mst_state_e          state;
   logic [CMD_WIDTH-1:0]    q_rdata;
   logic                    q_full;
   logic                    q_empty;
   logic                    pop;
   logic                    ready_en;
   logic                    c_write;
   logic [ADDR_WIDTH-1:0]   c_addr;
   logic [DATA_WIDTH-1:0]   c_wdata;
   logic [STRB_WIDTH-1:0]   c_strb;
   logic [NPA_WAIT_W-1:0]   wait_inc;
   logic                    timeout_hit;

   npa_sync_fifo #(
      .WIDTH (CMD_WIDTH),
      .DEPTH (CMD_DEPTH)
   ) u_cmd_q (
      .clk       (PCLK),
      .rst       (PRESET),
      .push      (cmd_valid & cmd_ready),
      .push_data ({cmd_write, cmd_addr, cmd_wdata, cmd_strb}),
      .pop       (pop),
      .pop_data  (q_rdata),
      .full      (q_full),
      .empty     (q_empty)
   );

   // ready_en holds cmd_ready low for the cycle the reset is sampled.
   assign cmd_ready = ready_en & ~q_full;
   assign {c_write, c_addr, c_wdata, c_strb} = q_rdata;
   assign pop = ~q_empty & ((state == ST_IDLE) | ((state == ST_RESP) & rsp_ready));
   assign wait_inc = npa_sat_inc(rsp_wait);
   assign timeout_hit = (TIMEOUT_C != 32'd0) &&
                        ({{(32 - NPA_WAIT_W){1'b0}}, wait_inc} >= TIMEOUT_C);

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state       <= ST_IDLE;
         ready_en    <= 1'b0;
         PSEL        <= 1'b0;
         PENABLE     <= 1'b0;
         PWRITE      <= 1'b0;
         PADDR       <= '0;
         PWDATA      <= '0;
         PSTRB       <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         rsp_wait    <= '0;
      end else begin
         ready_en <= 1'b1;
         case (state)
            ST_IDLE: ;
            ST_SETUP: begin
               PENABLE <= 1'b1;
               state   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (PREADY) begin
                  PSEL        <= 1'b0;
                  PENABLE     <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_rdata   <= PWRITE ? '0 : PRDATA;
                  rsp_err     <= PSLVERR;
                  rsp_timeout <= 1'b0;
                  state       <= ST_RESP;
               end else begin
                  rsp_wait <= wait_inc;
                  // Deliberate mid-transfer abort so a hung target cannot stall the bench.
                  if (timeout_hit) begin
                     PSEL        <= 1'b0;
                     PENABLE     <= 1'b0;
                     rsp_valid   <= 1'b1;
                     rsp_rdata   <= '0;
                     rsp_err     <= 1'b1;
                     rsp_timeout <= 1'b1;
                     state       <= ST_RESP;
                  end
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase

         // A pop from IDLE or from a completing RESP both launch SETUP next cycle.
         if (pop) begin
            PADDR    <= c_addr;
            PWRITE   <= c_write;
            PWDATA   <= c_wdata;
            PSTRB    <= c_write ? c_strb : '0;
            PSEL     <= 1'b1;
            PENABLE  <= 1'b0;
            rsp_wait <= '0;
            state    <= ST_SETUP;
         end
      end
   end

endmodule

// File: tb/tb_apb_traffic_master.sv
// tb/tb_apb_traffic_master.sv - directed vectors and corner sequences for apb_traffic_master
module tb_apb_traffic_master;
   import npa_apb_pkg::*;

   logic        PCLK = 1'b0;
   logic        PRESET;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_strb;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [15:0] rsp_wait;
   logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
   logic [31:0] PADDR, PWDATA, PRDATA;
   logic [3:0]  PSTRB;
   logic [31:0] prdata_drv;
   logic        echo;

   int n_chk  = 0;
   int n_fail = 0;

   localparam logic [31:0] ECHO_MASK = 32'h5A5A_0000;
   assign PRDATA = echo ? (PADDR ^ ECHO_MASK) : prdata_drv;

   apb_traffic_master dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .rsp_wait(rsp_wait),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
      .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      int          waits;
      logic [31:0] prdata;
      logic        slverr;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic [3:0]  exp_strb;
      logic [15:0] exp_wait;
   } vec_t;

   vec_t vecs [5];
   npa_apb_cmd_t q [5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_rsp(input string name, input int budget);
      int t = 0;
      while (!rsp_valid && t < budget) begin
         @(negedge PCLK);
         t++;
      end
      chk(name, {63'd0, rsp_valid}, 64'd1);
   endtask

   // Entry: FSM idle, queue empty, at a falling edge. Handshake cycle is cycle 0.
   task automatic run_vec(input vec_t v, input string tag);
      cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
      cmd_wdata = v.wdata; cmd_strb = v.strb;
      chk({tag, ".cmd_ready"}, {63'd0, cmd_ready}, 64'd1);
      @(negedge PCLK);
      cmd_valid = 1'b0;
      chk({tag, ".psel_c1"}, {63'd0, PSEL}, 64'd0);
      @(negedge PCLK);
      chk({tag, ".psel_c2"}, {62'd0, PSEL, PENABLE}, 64'd2);
      chk({tag, ".paddr"}, {32'd0, PADDR}, {32'd0, v.addr});
      chk({tag, ".pwrite"}, {63'd0, PWRITE}, {63'd0, v.write});
      chk({tag, ".pwdata"}, {32'd0, PWDATA}, {32'd0, v.wdata});
      chk({tag, ".pstrb"}, {60'd0, PSTRB}, {60'd0, v.exp_strb});
      @(negedge PCLK);
      chk({tag, ".penable_c3"}, {62'd0, PSEL, PENABLE}, 64'd3);
      prdata_drv = v.prdata; PSLVERR = v.slverr;
      for (int i = 0; i < v.waits; i++) begin
         PREADY = 1'b0;
         @(negedge PCLK);
         chk({tag, ".wait_access"}, {62'd0, PSEL, PENABLE}, 64'd3);
         chk({tag, ".paddr_hold"}, {32'd0, PADDR}, {32'd0, v.addr});
         chk({tag, ".pstrb_hold"}, {60'd0, PSTRB}, {60'd0, v.exp_strb});
      end
      PREADY = 1'b1;
      @(negedge PCLK);
      PREADY = 1'b0; PSLVERR = 1'b0;
      chk({tag, ".rsp_valid"}, {63'd0, rsp_valid}, 64'd1);
      chk({tag, ".bus_idle"}, {62'd0, PSEL, PENABLE}, 64'd0);
      chk({tag, ".rsp_rdata"}, {32'd0, rsp_rdata}, {32'd0, v.exp_rdata});
      chk({tag, ".rsp_err"}, {63'd0, rsp_err}, {63'd0, v.exp_err});
      chk({tag, ".rsp_timeout"}, {63'd0, rsp_timeout}, 64'd0);
      chk({tag, ".rsp_wait"}, {48'd0, rsp_wait}, {48'd0, v.exp_wait});
      @(negedge PCLK);
      chk({tag, ".rsp_hold"}, {31'd0, rsp_valid, rsp_rdata}, {31'd0, 1'b1, v.exp_rdata});
      rsp_ready = 1'b1;
      @(negedge PCLK);
      rsp_ready = 1'b0;
      chk({tag, ".rsp_done"}, {63'd0, rsp_valid}, 64'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      vecs[0] = '{1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0000_0000, 1'b0,
                  32'h0000_0000, 1'b0, 4'hF, 16'd0};
      vecs[1] = '{1'b0, 32'h2000_0004, 32'h1111_1111, 4'hF, 3, 32'h1234_5678, 1'b0,
                  32'h1234_5678, 1'b0, 4'h0, 16'd3};
      vecs[2] = '{1'b0, 32'h3000_0008, 32'h0000_0000, 4'h0, 0, 32'hAAAA_5555, 1'b1,
                  32'hAAAA_5555, 1'b1, 4'h0, 16'd0};
      vecs[3] = '{1'b1, 32'h3000_000C, 32'hCAFE_F00D, 4'h3, 2, 32'h0000_0000, 1'b1,
                  32'h0000_0000, 1'b1, 4'h3, 16'd2};
      vecs[4] = '{1'b1, 32'h4000_0020, 32'h0102_0304, 4'hC, 1, 32'hFFFF_FFFF, 1'b0,
                  32'h0000_0000, 1'b0, 4'hC, 16'd1};
      for (int i = 0; i < 5; i++) begin
         q[i] = '{1'b0, 32'h6000_0000 + 32'(i * 4), 32'h0, 4'hF};
      end

      PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; cmd_strb = '0; rsp_ready = 1'b0; PREADY = 1'b0;
      PSLVERR = 1'b0; prdata_drv = '0; echo = 1'b0;
      repeat (3) @(negedge PCLK);
      chk("reset.apb_ctrl", {61'd0, PSEL, PENABLE, PWRITE}, 64'd0);
      chk("reset.paddr_pwdata", {PADDR, PWDATA}, 64'd0);
      chk("reset.pstrb", {60'd0, PSTRB}, 64'd0);
      chk("reset.rsp_flags", {61'd0, rsp_valid, rsp_err, rsp_timeout}, 64'd0);
      chk("reset.rsp_data", {16'd0, rsp_wait, rsp_rdata}, 64'd0);
      PRESET = 1'b0;
      @(negedge PCLK);
      chk("reset.cmd_ready", {63'd0, cmd_ready}, 64'd1);

      for (int i = 0; i < 5; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Queue fill: park a write in RESP so the queue cannot drain.
      PREADY = 1'b1; echo = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4000_0000;
      cmd_wdata = 32'h5555_AAAA; cmd_strb = 4'hF;
      @(negedge PCLK);
      cmd_valid = 1'b0;
      wait_rsp("fill.park", 20);
      for (int i = 0; i < 4; i++) begin
         cmd_valid = 1'b1; cmd_write = q[i].write; cmd_addr = q[i].addr;
         cmd_wdata = q[i].wdata; cmd_strb = q[i].strb;
         @(negedge PCLK);
      end
      cmd_write = q[4].write; cmd_addr = q[4].addr; cmd_wdata = q[4].wdata; cmd_strb = q[4].strb;
      chk("fill.cmd_ready_low", {63'd0, cmd_ready}, 64'd0);
      repeat (3) begin
         @(negedge PCLK);
         chk("fill.stall", {62'd0, cmd_ready, rsp_valid}, 64'd1);
      end
      fork
         begin
            for (int t = 0; t < 40; t++) begin
               @(negedge PCLK);
               if (cmd_ready) begin
                  @(negedge PCLK);
                  cmd_valid = 1'b0;
                  break;
               end
            end
         end
      join_none
      rsp_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         wait_rsp($sformatf("order%0d.valid", k), 20);
         chk($sformatf("order%0d.rdata", k), {32'd0, rsp_rdata},
             {32'd0, (k == 0) ? 32'h0 : (q[k-1].addr ^ ECHO_MASK)});
         @(negedge PCLK);
         if (k < 5) begin
            chk($sformatf("order%0d.b2b_setup", k), {62'd0, PSEL, PENABLE}, 64'd2);
         end
      end
      rsp_ready = 1'b0; cmd_valid = 1'b0; echo = 1'b0; PREADY = 1'b0;
      repeat (2) @(negedge PCLK);

      // Timeout: target never raises PREADY.
      prdata_drv = 32'hFFFF_FFFF;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h5000_0000; cmd_strb = 4'hF;
      @(negedge PCLK);
      cmd_valid = 1'b0;
      acc = 0;
      for (int t = 0; t < 400 && !rsp_valid; t++) begin
         @(negedge PCLK);
         if (PENABLE) acc++;
      end
      chk("timeout.rsp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("timeout.access_cycles", 64'(acc), 64'd255);
      chk("timeout.flags", {62'd0, rsp_timeout, rsp_err}, 64'd3);
      chk("timeout.rdata", {32'd0, rsp_rdata}, 64'd0);
      chk("timeout.wait", {48'd0, rsp_wait}, 64'd255);
      chk("timeout.bus_idle", {62'd0, PSEL, PENABLE}, 64'd0);
      rsp_ready = 1'b1;
      @(negedge PCLK);
      rsp_ready = 1'b0;

      // Reset during ACCESS with two commands still queued.
      for (int i = 0; i < 3; i++) begin
         cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h7000_0000 + 32'(i * 4);
         cmd_wdata = 32'(i); cmd_strb = 4'hF;
         @(negedge PCLK);
      end
      cmd_valid = 1'b0;
      for (int t = 0; t < 10 && !PENABLE; t++) @(negedge PCLK);
      chk("rst_mid.in_access", {63'd0, PENABLE}, 64'd1);
      PRESET = 1'b1;
      @(negedge PCLK);
      chk("rst_mid.bus_idle", {62'd0, PSEL, PENABLE}, 64'd0);
      chk("rst_mid.no_rsp", {63'd0, rsp_valid}, 64'd0);
      PRESET = 1'b0;
      @(negedge PCLK);
      chk("rst_mid.cmd_ready", {63'd0, cmd_ready}, 64'd1);
      repeat (4) begin
         @(negedge PCLK);
         chk("rst_mid.flushed", {62'd0, PSEL, rsp_valid}, 64'd0);
      end
      run_vec(vecs[1], "post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_traffic_master.md
# apb_traffic_master

Active APB4 requester that turns queued commands into APB transfers and returns one response per command with read data, error, timeout and wait-state count. It is the initiator-side counterpart to the passive APB target monitors. It drives CRU/peripheral APB targets in NoC performance benches so that target-side monitors log real traffic.

## Interface
Parameters:
- ADDR_WIDTH, 32, PADDR/cmd_addr width
- DATA_WIDTH, 32, PWDATA/PRDATA width; multiple of 8; PSTRB width = DATA_WIDTH/8
- CMD_DEPTH, 4, command queue entries; power of 2, ≥2
- TIMEOUT, 255, max ACCESS cycles with PREADY low before abort; 0 disables timeout

Ports:
- PCLK  in  1  clock; one clock domain
- PRESET  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  queue not full
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data
- cmd_strb  in  DATA_WIDTH/8  write strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts
- rsp_err  out  1  PSLVERR sampled, or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- rsp_wait  out  16  ACCESS cycles with PREADY low, saturating at 0xFFFF
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDR_WIDTH; PWDATA  out  DATA_WIDTH; PSTRB  out  DATA_WIDTH/8
- PRDATA  in  DATA_WIDTH; PREADY  in  1; PSLVERR  in  1

## Operation
- Command queue (sync FIFO, CMD_DEPTH entries): push on cmd_valid&cmd_ready; cmd_ready = !full (registered count, no same-cycle bypass when full).
- Pop and push in the same cycle leave the count unchanged.
- FSM states: IDLE, SETUP, ACCESS, RESP.
  - IDLE: queue non-empty → pop into transfer regs → SETUP.
  - SETUP: PSEL=1, PENABLE=0 for exactly one cycle → ACCESS.
  - ACCESS: PSEL=1, PENABLE=1.
    - PREADY=1 → capture PRDATA (reads only) and PSLVERR → RESP.
    - PREADY=0 → increment wait counter.
    - TIMEOUT≠0 and wait counter reaches TIMEOUT with PREADY low → drop PSEL/PENABLE; rsp_timeout=1, rsp_err=1, rdata=0 → RESP. This deliberate protocol abort is for bench use only.
  - RESP: rsp_valid=1; response fields stable until rsp_ready. On handshake: queue non-empty → pop and go to SETUP directly; else IDLE.
- PADDR/PWRITE/PWDATA/PSTRB are loaded at pop and held through SETUP and ACCESS, then keep their last value in IDLE/RESP. PSTRB is driven 0 for reads.
- Only one APB transfer is outstanding at a time; responses return in command order.

## Timing
- All outputs registered. Reset values: PSEL=PENABLE=PWRITE=0, PADDR=PWDATA=PSTRB=0, rsp_valid=0, rsp_rdata=0, rsp_err=rsp_timeout=0, rsp_wait=0.
- cmd_ready resets to 1 on the cycle after PRESET deasserts.
- Handshake in cycle 0 with empty queue and FSM in IDLE → PSEL rises in cycle 2. With a zero-wait target, ACCESS is in cycle 3 and rsp_valid rises in cycle 4.
- Back-to-back: rsp handshake in cycle n with queue non-empty → SETUP in cycle n+1.
- The wait counter clears on entry to SETUP.
- Reset mid-transfer: PSEL/PENABLE low on the cycle after the reset edge, queue flushed, pending response discarded, FSM to IDLE.

## Structure
- Package npa_apb_pkg: state enum apb_mst_state_e, constant NPA_WAIT_W=16, command struct typedef (write, addr, wdata, strb) parameterised via localparam widths.
- Sub-module npa_sync_fifo (WIDTH, DEPTH): registered count, full/empty, pointer wrap at DEPTH. Reusable by later AXI/AHB requesters.

## Test plan
- Single write: addr 0x1000_0010, wdata 0xDEAD_BEEF, strb 0xF, target PREADY=1 → PSEL in cycle 2, PENABLE in cycle 3, rsp_valid in cycle 4, rsp_err=0, rsp_wait=0, rsp_rdata=0.
- Read with 3 wait states, PRDATA=0x1234_5678 → rsp_rdata=0x1234_5678, rsp_wait=3, PSTRB=0 throughout, PADDR stable SETUP..ACCESS.
- Fill queue with 5 commands, rsp_ready held low → cmd_ready low after 4 pushes. Release rsp_ready → 5 responses in order, SETUP immediately follows each rsp handshake.
- PSLVERR=1 on read → rsp_err=1, rsp_timeout=0. PREADY stuck low with TIMEOUT=255 → abort after 255 wait cycles, rsp_timeout=1, rsp_err=1, rsp_rdata=0, rsp_wait=255.
- PRESET asserted during ACCESS with 2 queued commands → PSEL=0 the next cycle, no rsp_valid, cmd_ready=1, first new command after reset starts from an empty queue.
